// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian words from a byte
// stream, writes them from address 0, and releases the CPU only on a matching checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]      state;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] widx;
    logic [ADDR_W:0] widx_next;
    logic [1:0]      bidx;
    logic [23:0]     partial;
    logic [31:0]     sum;
    logic [31:0]     word;
    logic            xfer;

    // A byte moves only on a cycle where in_valid && in_ready; the producer may
    // drop in_valid at any time, and in_ready depends on state alone.
    assign in_ready  = (state != IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign xfer      = in_valid && in_ready;
    assign word      = {in_byte, partial};
    assign widx_next = widx + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            widx      <= '0;
            bidx      <= 2'd0;
            partial   <= 24'd0;
            sum       <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= word_count;
                        widx     <= '0;
                        bidx     <= 2'd0;
                        partial  <= 24'd0;
                        sum      <= 32'd0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        state    <= (word_count == '0) ? CHECK : LOAD;
                    end
                end
                LOAD, CHECK: begin
                    if (xfer) begin
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: partial[7:0]   <= in_byte;
                            2'd1: partial[15:8]  <= in_byte;
                            2'd2: partial[23:16] <= in_byte;
                            default: begin
                                if (state == LOAD) begin
                                    mem_we    <= 1'b1;
                                    mem_addr  <= widx[ADDR_W-1:0];
                                    mem_wdata <= word;
                                    sum       <= sum + word;
                                    widx      <= widx_next;
                                    if (widx_next == count)
                                        state <= CHECK;
                                end else begin
                                    // Mismatch keeps the CPU held until a clean reload.
                                    done     <= 1'b1;
                                    err      <= (word != sum);
                                    cpu_hold <= (word != sum);
                                    state    <= IDLE;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
